// File: rtl/io_switch_debounce_pkg.sv
// io_switch_debounce_pkg
//   Shared constants and elaboration-time helpers for the switch/key input
//   conditioning block (io_switch_debounce and its per-bit debouncer).
//   Contents:
//     NUM_PORTS               number of switch ports handled by the top (2)
//     WIDTH_DEFAULT           default bits per port
//     DEBOUNCE_CYCLES_DEFAULT default hold time in io_clk cycles
//     PORT_RESET_BIT          value every debounced output bit takes in reset
//     clog2 / cnt_width       counter sizing helpers
package io_switch_debounce_pkg;

  localparam int NUM_PORTS               = 2;
  localparam int WIDTH_DEFAULT           = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam logic PORT_RESET_BIT        = 1'b0;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Stability counter width; at least one bit so DEBOUNCE_CYCLES=1 still
  // elaborates a legal (never incremented) counter.
  function automatic int cnt_width(input int cycles);
    int w;
    w = clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/io_switch_debounce_bit.sv
// io_switch_debounce_bit
//   One switch bit: 2-flop synchronizer into io_clk followed by a stability
//   counter. The output only takes the synchronized level after that level
//   has differed from the output for DEBOUNCE_CYCLES consecutive cycles.
//   Ports:
//     io_clk  in   clock, all state on posedge
//     reset   in   synchronous active-high reset
//     raw_i   in   raw asynchronous switch level
//     out_o   out  debounced level (registered)
module io_switch_debounce_bit
  import io_switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic io_clk,
  input  logic reset,
  input  logic raw_i,
  output logic out_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             out_q;
  logic             out_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where the synchronized level agrees with the output restarts
  // the count, so a bounce always costs a full new hold period.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (sync2_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      sync1_q <= PORT_RESET_BIT;
      sync2_q <= PORT_RESET_BIT;
      out_q   <= PORT_RESET_BIT;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/io_switch_debounce.sv
// io_switch_debounce
//   Conditions the raw board switch/key inputs before the I/O input register
//   stage. Every bit of both ports is synchronized and debounced on its own;
//   a registered one-cycle strobe per port flags any change of that port.
//   Ports:
//     io_clk        in   sole clock
//     reset         in   synchronous active-high reset
//     sw_raw0/1     in   raw asynchronous switch inputs, WIDTH bits per port
//     in_port0/1    out  debounced ports (registered)
//     port_changed  out  bit p high for one cycle after in_portp changed
module io_switch_debounce
  import io_switch_debounce_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 io_clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     sw_raw0,
  input  logic [WIDTH-1:0]     sw_raw1,
  output logic [WIDTH-1:0]     in_port0,
  output logic [WIDTH-1:0]     in_port1,
  output logic [NUM_PORTS-1:0] port_changed
);

  logic [NUM_PORTS-1:0][WIDTH-1:0] raw_w;
  logic [NUM_PORTS-1:0][WIDTH-1:0] deb_w;
  logic [NUM_PORTS-1:0][WIDTH-1:0] prev_q;
  logic [NUM_PORTS-1:0]            changed_q;
  logic [NUM_PORTS-1:0]            changed_d;

  assign raw_w[0] = sw_raw0;
  assign raw_w[1] = sw_raw1;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
        io_switch_debounce_bit #(
          .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
          .io_clk(io_clk),
          .reset (reset),
          .raw_i (raw_w[gi][gb]),
          .out_o (deb_w[gi][gb])
        );
      end
      // The debounced value is already registered; comparing it with its
      // one-cycle-old copy gives a strobe one cycle after the update.
      assign changed_d[gi] = (deb_w[gi] != prev_q[gi]);
    end
  endgenerate

  always_ff @(posedge io_clk) begin
    if (reset) begin
      prev_q    <= {(NUM_PORTS*WIDTH){PORT_RESET_BIT}};
      changed_q <= '0;
    end else begin
      prev_q    <= deb_w;
      changed_q <= changed_d;
    end
  end

  assign in_port0     = deb_w[0];
  assign in_port1     = deb_w[1];
  assign port_changed = changed_q;

endmodule

// File: tb/tb_io_switch_debounce.sv
module tb_io_switch_debounce;

  localparam int W  = 5;
  localparam int DC = 4;

  logic         io_clk;
  logic         reset;
  logic [W-1:0] sw_raw0;
  logic [W-1:0] sw_raw1;
  logic [W-1:0] in_port0;
  logic [W-1:0] in_port1;
  logic [1:0]   port_changed;

  int checks;
  int failures;

  io_switch_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .io_clk      (io_clk),
    .reset       (reset),
    .sw_raw0     (sw_raw0),
    .sw_raw1     (sw_raw1),
    .in_port0    (in_port0),
    .in_port1    (in_port1),
    .port_changed(port_changed)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  // Reference model: the synchronizer is a plain 2-sample delay; a port bit
  // takes a new level once the last DC delayed samples (all taken since
  // reset) agree on a level different from the current output.
  logic [W-1:0] m_s1   [2];
  logic [W-1:0] m_s2   [2];
  logic [W-1:0] m_out  [2];
  logic [W-1:0] m_hist [2][DC];
  int           m_hcnt [2];
  logic [1:0]   m_chg;
  logic [1:0]   m_flag;

  task automatic model_edge();
    logic [W-1:0] raw [2];
    logic [W-1:0] nv;
    bit same;
    raw[0] = sw_raw0;
    raw[1] = sw_raw1;
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        m_s1[p] = '0; m_s2[p] = '0; m_out[p] = '0; m_hcnt[p] = 0;
        m_chg[p] = 1'b0; m_flag[p] = 1'b0;
      end else begin
        for (int k = DC - 1; k > 0; k--) m_hist[p][k] = m_hist[p][k-1];
        m_hist[p][0] = m_s2[p];
        if (m_hcnt[p] < DC) m_hcnt[p]++;
        nv = m_out[p];
        if (m_hcnt[p] == DC) begin
          for (int b = 0; b < W; b++) begin
            same = 1'b1;
            for (int k = 1; k < DC; k++)
              if (m_hist[p][k][b] != m_hist[p][0][b]) same = 1'b0;
            if (same && (m_hist[p][0][b] != m_out[p][b])) nv[b] = m_hist[p][0][b];
          end
        end
        m_chg[p]  = m_flag[p];
        m_flag[p] = (nv != m_out[p]);
        m_out[p]  = nv;
        m_s2[p]   = m_s1[p];
        m_s1[p]   = raw[p];
      end
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    model_edge();
    #1;
  endtask

  task automatic settle(input logic [W-1:0] v0, input logic [W-1:0] v1);
    sw_raw0 = v0;
    sw_raw1 = v1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    logic [1:0]   ec;
    int f0;
    f0 = failures;
    sw_raw0 = 5'h1F; sw_raw1 = 5'h1F; reset = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      checks++;
      if (in_port0 !== 5'h00 || in_port1 !== 5'h00 || port_changed !== 2'b00) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got p0=%h p1=%h chg=%b want 00 00 00", n, in_port0, in_port1, port_changed);
      end
    end
    reset = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      e  = (n >= 6) ? 5'h1F : 5'h00;
      ec = (n == 7) ? 2'b11 : 2'b00;
      checks++;
      if (in_port0 !== e || in_port1 !== e) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got p0=%h p1=%h want %h", n, in_port0, in_port1, e);
      end
      checks++;
      if (port_changed !== ec) begin
        failures++;
        $display("FAIL reset_strobe cyc=%0d got %b want %b", n, port_changed, ec);
      end
    end
    $display("test_reset done errors=%0d", failures - f0);
  endtask

  task automatic test_single();
    logic [1:0] ec;
    int f0;
    f0 = failures;
    settle(5'h00, 5'h00);
    sw_raw0 = 5'h01;
    for (int n = 1; n <= 9; n++) begin
      tick();
      ec = (n == 7) ? 2'b01 : 2'b00;
      checks++;
      if (in_port0 !== ((n >= 6) ? 5'h01 : 5'h00) || in_port1 !== 5'h00) begin
        failures++;
        $display("FAIL single_latency cyc=%0d got p0=%h p1=%h want p0=%h p1=00", n, in_port0, in_port1, (n >= 6) ? 5'h01 : 5'h00);
      end
      checks++;
      if (port_changed !== ec) begin
        failures++;
        $display("FAIL single_strobe cyc=%0d got %b want %b", n, port_changed, ec);
      end
    end
    $display("test_single done errors=%0d", failures - f0);
  endtask

  task automatic test_glitch();
    int f0;
    f0 = failures;
    for (int n = 1; n <= 20; n++) begin
      sw_raw1 = (n <= 3) ? 5'h08 : 5'h00;
      tick();
      checks++;
      if (in_port1 !== 5'h00 || port_changed !== 2'b00 || in_port0 !== 5'h01) begin
        failures++;
        $display("FAIL glitch cyc=%0d got p0=%h p1=%h chg=%b want 01 00 00", n, in_port0, in_port1, port_changed);
      end
    end
    $display("test_glitch done errors=%0d", failures - f0);
  endtask

  task automatic test_bounce();
    logic [1:0] ec;
    int f0;
    f0 = failures;
    settle(5'h00, 5'h00);
    for (int n = 1; n <= 12; n++) begin
      sw_raw0 = (n > 5 || (n % 2) == 1) ? 5'h04 : 5'h00;
      tick();
      ec = (n == 11) ? 2'b01 : 2'b00;
      checks++;
      if (in_port0 !== ((n >= 10) ? 5'h04 : 5'h00)) begin
        failures++;
        $display("FAIL bounce cyc=%0d got %h want %h", n, in_port0, (n >= 10) ? 5'h04 : 5'h00);
      end
      checks++;
      if (port_changed !== ec) begin
        failures++;
        $display("FAIL bounce_strobe cyc=%0d got %b want %b", n, port_changed, ec);
      end
    end
    $display("test_bounce done errors=%0d", failures - f0);
  endtask

  task automatic test_reset_mid();
    int f0;
    f0 = failures;
    settle(5'h00, 5'h00);
    sw_raw0 = 5'h10;
    for (int n = 1; n <= 3; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (in_port0 !== 5'h00 || port_changed !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_clear got p0=%h chg=%b want 00 00", in_port0, port_changed);
    end
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (in_port0 !== ((n >= 6) ? 5'h10 : 5'h00)) begin
        failures++;
        $display("FAIL reset_mid_restart cyc=%0d got %h want %h", n, in_port0, (n >= 6) ? 5'h10 : 5'h00);
      end
    end
    $display("test_reset_mid done errors=%0d", failures - f0);
  endtask

  task automatic test_simultaneous();
    logic [1:0] ec;
    int f0;
    f0 = failures;
    settle(5'h00, 5'h00);
    sw_raw0 = 5'h0A;
    sw_raw1 = 5'h15;
    for (int n = 1; n <= 9; n++) begin
      tick();
      ec = (n == 7) ? 2'b11 : 2'b00;
      checks++;
      if (in_port0 !== ((n >= 6) ? 5'h0A : 5'h00) || in_port1 !== ((n >= 6) ? 5'h15 : 5'h00)) begin
        failures++;
        $display("FAIL simul_ports cyc=%0d got p0=%h p1=%h", n, in_port0, in_port1);
      end
      checks++;
      if (port_changed !== ec) begin
        failures++;
        $display("FAIL simul_strobe cyc=%0d got %b want %b", n, port_changed, ec);
      end
    end
    $display("test_simultaneous done errors=%0d", failures - f0);
  endtask

  task automatic test_random();
    int f0;
    f0 = failures;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) sw_raw0 = sw_raw0 ^ W'(1 << $urandom_range(0, W - 1));
      if ($urandom_range(0, 2) == 0) sw_raw1 = sw_raw1 ^ W'(1 << $urandom_range(0, W - 1));
      if ($urandom_range(0, 19) == 0) sw_raw0 = W'($urandom);
      if ($urandom_range(0, 19) == 0) sw_raw1 = W'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if (in_port0 !== m_out[0] || in_port1 !== m_out[1] || port_changed !== m_chg) begin
        failures++;
        $display("FAIL random cyc=%0d got p0=%h p1=%h chg=%b want p0=%h p1=%h chg=%b",
                 n, in_port0, in_port1, port_changed, m_out[0], m_out[1], m_chg);
      end
    end
    reset = 1'b0;
    $display("test_random done errors=%0d", failures - f0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    sw_raw0 = '0;
    sw_raw1 = '0;
    for (int p = 0; p < 2; p++) begin
      m_s1[p] = '0; m_s2[p] = '0; m_out[p] = '0; m_hcnt[p] = 0;
      for (int k = 0; k < DC; k++) m_hist[p][k] = '0;
    end
    m_chg = '0;
    m_flag = '0;
    #2;
    test_reset();
    test_single();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
